link_serial: RTL and testbench
==============================

Name: link_serial

Overview:
- Game Boy serial-port transfer engine for the gb-link subsystem: SB data register, SC control register, 8-bit shift with internal or external serial clock.
- Sits between the CPU register bus and the link-cable pins.
- Consumes the system clock-enable tick.
- Produces the serial clock/data toward the cable and a one-cycle transfer-complete interrupt toward the interrupt controller.

Parameters:
HALF_DIV, 256, ce ticks per half serial-clock period in internal mode (256 -> 8192 Hz at 4.194304 MHz ce); minimum 2
SYNC_STAGES, 2, synchronizer depth for sclk_in/sdata_in; minimum 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ce  in  1  CPU-rate clock enable; gates internal divider only
wr_sb  in  1  write strobe, SB register
wr_sc  in  1  write strobe, SC register
din  in  8  CPU write data
sb  out  8  SB read value (shift register)
sc  out  8  SC read value = {busy, 6'b111111, clk_sel}
irq  out  1  one-clk pulse on transfer completion
busy  out  1  transfer in progress (SC bit 7)
sclk_in  in  1  external serial clock from cable (async)
sdata_in  in  1  serial data from cable (async)
sclk_out  out  1  serial clock driven when clk_sel=1
sdata_out  out  1  serial data to cable

Behaviour:
- Clocking: single clock clk; reset is synchronous and active-high on rst; all state updates on posedge clk.
- Reset values: sb=8'h00, busy=0, clk_sel=0 (sc=8'h7E), irq=0, sclk_out=1, sdata_out=1, bit counter=0, divider=0, FSM=IDLE.
- FSM states:
  - IDLE -> (wr_sc with din[7]=1) -> LOW.
  - LOW -> (half-period done) -> HIGH.
  - HIGH -> (half-period done, count<8) -> LOW.
  - Completion of 8th sample -> IDLE.
- Start: wr_sc latches clk_sel=din[0], busy=din[7]. If busy goes 1, load sdata_out=sb[7], counter=0, divider=0.
- Internal mode (clk_sel=1):
  - sclk_out goes low the cycle after start.
  - The divider counts ce ticks and toggles sclk_out every HALF_DIV ticks.
  - ce=0 freezes the divider.
- Falling edge of serial clock (internal toggle to 0, or synced sclk_in 1->0): sdata_out <= sb[7].
- Rising edge (internal toggle to 1, or synced sclk_in 0->1): sb <= {sb[6:0], sdata_in_sync}, counter++.
- Completion on the 8th rising edge, all in that same clk cycle:
  - final shift;
  - busy cleared;
  - irq=1 for exactly one clk;
  - FSM -> IDLE;
  - sclk_out stays 1;
  - sdata_out stays at last driven value until next start.
- Timing (ce=1 continuously, start write in cycle 0): rising edge k occurs in cycle 1+(2k-1)*HALF_DIV; irq in cycle 1+15*HALF_DIV.
- External mode (clk_sel=0):
  - sclk_out held 1; divider idle.
  - Edges come from the SYNC_STAGES-synchronized sclk_in; edge detection is not gated by ce.
  - sclk_in edges while busy=0 are ignored.
- Abort: wr_sc with din[7]=0 while busy -> IDLE next cycle; no irq; sb keeps partially shifted value; counter cleared; sclk_out=1.
- wr_sc with din[7]=1 while busy restarts the transfer (counter=0, divider=0).
- wr_sb while busy=0: sb<=din. wr_sb while busy=1: ignored.
- Simultaneous events:
  - wr_sc and wr_sb in the same cycle: wr_sc applied, wr_sb ignored.
  - wr_sc in the completion cycle: the write wins, and irq still pulses.
- Reset mid-transfer: immediate return to reset values; no irq.

Decomposition:
- link_pkg holds:
  - FSM state enum (IDLE, LOW, HIGH);
  - SC bit positions (SC_START=7, SC_CLKSEL=0);
  - SC_RD_FILL=6'b111111;
  - BITS_PER_XFER=8.
- Sub-module link_sync: SYNC_STAGES flop chain plus rise/fall edge pulses; one instance each for sclk_in and sdata_in (data uses the level only).

Test Plan:
- Internal transfer, HALF_DIV=4:
  - Stimulus: write SB=8'hA5, SC=8'h81; sdata_in held 1.
  - Response: sdata_out bit sequence 1,0,1,0,0,1,0,1; 8 sclk_out low pulses of 4 cycles each; irq single pulse at cycle 61; sb=8'hFF; sc=8'h7F.
- External transfer:
  - Stimulus: write SB=8'h3C, SC=8'h80; drive sclk_in 8 periods of 20 clk; sdata_in pattern 8'hC3 MSB first.
  - Response: sb=8'hC3; sdata_out emits 8'h3C MSB first; one irq; sclk_out constant 1.
- ce gating: internal transfer with ce toggling 1/0 -> all edge timings stretched exactly 2x; irq at cycle 121 (HALF_DIV=4).
- Abort:
  - Stimulus: internal start; write SC=8'h01 after 3 rising edges.
  - Response: busy=0 next cycle; no irq; sclk_out=1; a subsequent start completes normally.
- Protection/priority:
  - wr_sb=8'h55 during busy -> sb unchanged.
  - wr_sb and wr_sc (din=8'h80) in the same cycle while idle -> sb unchanged, transfer starts.
- Reset mid-transfer: assert rst at bit 5 -> next cycle sb=0, sc=8'h7E, sclk_out=1, sdata_out=1, irq never asserted.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and constants for the link-cable serial transfer engine.
package link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH
   } state_t;

   localparam int SC_START      = 7;
   localparam int SC_CLKSEL     = 0;
   localparam logic [5:0] SC_RD_FILL = 6'b111111;
   localparam int BITS_PER_XFER = 8;

   // SC read image: unused bits read back as ones.
   function automatic logic [7:0] sc_pack(input logic busy, input logic clk_sel);
      return {busy, SC_RD_FILL, clk_sel};
   endfunction

endpackage

// File: rtl/link_serial_if.sv
// CPU register-bus view of the serial port: SB/SC write strobes, read values, interrupt.
interface link_serial_if;
   logic       wr_sb;
   logic       wr_sc;
   logic [7:0] din;
   logic [7:0] sb;
   logic [7:0] sc;
   logic       irq;
   logic       busy;

   modport master (
      output wr_sb, wr_sc, din,
      input  sb, sc, irq, busy
   );

   modport slave (
      input  wr_sb, wr_sc, din,
      output sb, sc, irq, busy
   );
endinterface

// File: rtl/link_sync.sv
// Multi-flop synchronizer for an asynchronous cable pin, with rise/fall pulses on the synced level.
module link_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_p;
   logic                   level_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p     <= {SYNC_STAGES{RST_VAL}};
         level_prev <= RST_VAL;
      end else begin
         sync_p     <= {sync_p[SYNC_STAGES-2:0], async_in};
         level_prev <= sync_p[SYNC_STAGES-1];
      end
   end

   assign level = sync_p[SYNC_STAGES-1];
   assign rise  = level & ~level_prev;
   assign fall  = ~level & level_prev;

endmodule

// File: rtl/link_serial.sv
// Serial-port transfer engine: SB shift register, SC control, internal divider or external
// cable clock, one-clock completion interrupt.
module link_serial
   import link_pkg::*;
#(
   parameter int HALF_DIV    = 256,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   link_serial_if.slave  bus,
   input  logic          sclk_in,
   input  logic          sdata_in,
   output logic          sclk_out,
   output logic          sdata_out
);

   localparam int DIV_W = $clog2(HALF_DIV);
   localparam int CNT_W = $clog2(BITS_PER_XFER + 1);

   state_t            state, state_n;
   logic              clk_sel, clk_sel_n;
   logic [7:0]        shift_reg, shift_reg_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [DIV_W-1:0]  div, div_n;
   logic              sclk_n, sdo_n;
   logic              irq_pulse, irq_n;
   logic              busy;
   logic              rise_ev, fall_ev;

   logic sclk_level, sclk_rise, sclk_fall;
   logic sdi_level, sdi_rise, sdi_fall;
   logic unused_sync_bits;

   link_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
      .clk      (clk),
      .rst      (rst),
      .async_in (sclk_in),
      .level    (sclk_level),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   link_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sdata (
      .clk      (clk),
      .rst      (rst),
      .async_in (sdata_in),
      .level    (sdi_level),
      .rise     (sdi_rise),
      .fall     (sdi_fall)
   );

   assign unused_sync_bits = sclk_level ^ sdi_rise ^ sdi_fall;

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         clk_sel   <= 1'b0;
         shift_reg <= 8'h00;
         cnt       <= '0;
         div       <= '0;
         sclk_out  <= 1'b1;
         sdata_out <= 1'b1;
         irq_pulse <= 1'b0;
      end else begin
         state     <= state_n;
         clk_sel   <= clk_sel_n;
         shift_reg <= shift_reg_n;
         cnt       <= cnt_n;
         div       <= div_n;
         sclk_out  <= sclk_n;
         sdata_out <= sdo_n;
         irq_pulse <= irq_n;
      end
   end

   always_comb begin
      state_n     = state;
      clk_sel_n   = clk_sel;
      shift_reg_n = shift_reg;
      cnt_n       = cnt;
      div_n       = div;
      sclk_n      = sclk_out;
      sdo_n       = sdata_out;
      irq_n       = 1'b0;
      rise_ev     = 1'b0;
      fall_ev     = 1'b0;

      // Edge source: divider in internal mode, synchronized cable clock otherwise.
      if (busy) begin
         if (clk_sel) begin
            if (ce) begin
               if (div == DIV_W'(HALF_DIV - 1)) begin
                  div_n = '0;
                  if (state == ST_LOW) rise_ev = 1'b1;
                  else                 fall_ev = 1'b1;
               end else begin
                  div_n = div + 1'b1;
               end
            end
         end else begin
            rise_ev = sclk_rise;
            fall_ev = sclk_fall;
         end
      end

      if (fall_ev) begin
         sdo_n   = shift_reg[7];
         state_n = ST_LOW;
         if (clk_sel) sclk_n = 1'b0;
      end

      if (rise_ev) begin
         shift_reg_n = {shift_reg[6:0], sdi_level};
         state_n     = ST_HIGH;
         if (clk_sel) sclk_n = 1'b1;
         if (cnt == CNT_W'(BITS_PER_XFER - 1)) begin
            cnt_n   = '0;
            irq_n   = 1'b1;
            state_n = ST_IDLE;
         end else begin
            cnt_n = cnt + 1'b1;
         end
      end

      // A CPU write to SC overrides any serial event in the same cycle; irq is kept.
      if (bus.wr_sc) begin
         clk_sel_n = bus.din[SC_CLKSEL];
         cnt_n     = '0;
         div_n     = '0;
         if (bus.din[SC_START]) begin
            state_n = ST_LOW;
            sdo_n   = shift_reg[7];
            sclk_n  = ~bus.din[SC_CLKSEL];
         end else begin
            state_n = ST_IDLE;
            sclk_n  = 1'b1;
         end
      end else if (bus.wr_sb && !busy) begin
         shift_reg_n = bus.din;
      end
   end

   assign bus.sb   = shift_reg;
   assign bus.sc   = sc_pack(busy, clk_sel);
   assign bus.irq  = irq_pulse;
   assign bus.busy = busy;

endmodule

// File: tb/tb_link_serial.sv
// Directed bench for link_serial: internal/external transfers, ce gating, abort, priority, reset.
module tb_link_serial;

   localparam int HALF_DIV    = 4;
   localparam int SYNC_STAGES = 2;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic ce       = 1'b1;
   logic sclk_in  = 1'b1;
   logic sdata_in = 1'b1;
   logic sclk_out;
   logic sdata_out;

   int n_chk     = 0;
   int n_err     = 0;
   int irq_total = 0;

   link_serial_if bus();

   link_serial #(.HALF_DIV(HALF_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .bus       (bus),
      .sclk_in   (sclk_in),
      .sdata_in  (sdata_in),
      .sclk_out  (sclk_out),
      .sdata_out (sdata_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.irq === 1'b1) irq_total <= irq_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_sb(input logic [7:0] d);
      bus.din   = d;
      bus.wr_sb = 1'b1;
      step(1);
      bus.wr_sb = 1'b0;
   endtask

   task automatic write_sc(input logic [7:0] d);
      bus.din   = d;
      bus.wr_sc = 1'b1;
      step(1);
      bus.wr_sc = 1'b0;
   endtask

   // Cycle 1 is the first cycle after the SC write; records sclk_out low pulses and irq.
   task automatic run_monitor(input int ncyc, input bit ce_toggle,
                              output int irq_cyc, output int irq_cnt, output int pulses,
                              output int min_len, output int max_len, output logic [7:0] bits);
      bit prev_low;
      int run;
      irq_cyc  = -1;
      irq_cnt  = 0;
      pulses   = 0;
      min_len  = 9999;
      max_len  = 0;
      bits     = 8'h00;
      prev_low = 1'b0;
      run      = 0;
      for (int c = 1; c <= ncyc; c++) begin
         ce = ce_toggle ? (c % 2 == 0) : 1'b1;
         @(negedge clk);
         if (bus.irq) begin
            irq_cnt++;
            irq_cyc = c;
         end
         if (!sclk_out) begin
            if (!prev_low) begin
               pulses++;
               bits = {bits[6:0], sdata_out};
               run  = 0;
            end
            run++;
         end else if (prev_low) begin
            if (run < min_len) min_len = run;
            if (run > max_len) max_len = run;
         end
         prev_low = !sclk_out;
         @(posedge clk);
         #1;
      end
      ce = 1'b1;
   endtask

   int         irq_cyc, irq_cnt, pulses, min_len, max_len, irq0;
   logic [7:0] bits, ext_bits, pat;
   bit         sclk_ok;

   initial begin
      bus.wr_sb = 1'b0;
      bus.wr_sc = 1'b0;
      bus.din   = 8'h00;

      rst = 1'b1;
      step(3);
      @(negedge clk);
      check("reset_sb",   32'(bus.sb),   'h00);
      check("reset_sc",   32'(bus.sc),   'h7E);
      check("reset_irq",  32'(bus.irq),  'h0);
      check("reset_busy", 32'(bus.busy), 'h0);
      check("reset_sclk", 32'(sclk_out), 'h1);
      check("reset_sdo",  32'(sdata_out),'h1);
      rst = 1'b0;
      step(2);

      // Internal transfer, ce always on.
      write_sb(8'hA5);
      @(negedge clk);
      check("sb_write", 32'(bus.sb), 'hA5);
      step(1);
      write_sc(8'h81);
      run_monitor(70, 1'b0, irq_cyc, irq_cnt, pulses, min_len, max_len, bits);
      check("int_irq_cycle", 32'(irq_cyc), 61);
      check("int_irq_count", 32'(irq_cnt), 1);
      check("int_pulses",    32'(pulses),  8);
      check("int_min_len",   32'(min_len), 4);
      check("int_max_len",   32'(max_len), 4);
      check("int_sdo_bits",  32'(bits),    'hA5);
      @(negedge clk);
      check("int_sb_end",   32'(bus.sb),   'hFF);
      check("int_sc_end",   32'(bus.sc),   'h7F);
      check("int_sclk_end", 32'(sclk_out), 'h1);
      step(1);

      // SC write landing on the completion edge: restart wins, irq still fires.
      write_sc(8'h81);
      step(59);
      write_sc(8'h81);
      @(negedge clk);
      check("cmpl_wr_irq",  32'(bus.irq),  'h1);
      check("cmpl_wr_busy", 32'(bus.busy), 'h1);
      write_sc(8'h01);
      step(2);

      // ce toggling halves the tick rate.
      write_sb(8'hA5);
      write_sc(8'h81);
      run_monitor(130, 1'b1, irq_cyc, irq_cnt, pulses, min_len, max_len, bits);
      check("ce_irq_cycle", 32'(irq_cyc), 121);
      check("ce_irq_count", 32'(irq_cnt), 1);
      check("ce_pulses",    32'(pulses),  8);
      check("ce_min_len",   32'(min_len), 8);
      check("ce_max_len",   32'(max_len), 8);
      check("ce_sdo_bits",  32'(bits),    'hA5);

      // Abort after three rising edges, then a clean restart.
      sdata_in = 1'b0;
      write_sb(8'hF0);
      step(2);
      write_sc(8'h81);
      step(21);
      irq0 = irq_total;
      write_sc(8'h01);
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 'h0);
      check("abort_sclk", 32'(sclk_out), 'h1);
      check("abort_sb",   32'(bus.sb),   'h80);
      check("abort_sc",   32'(bus.sc),   'h7F);
      step(41);
      check("abort_no_irq", 32'(irq_total - irq0), 0);
      write_sc(8'h81);
      run_monitor(70, 1'b0, irq_cyc, irq_cnt, pulses, min_len, max_len, bits);
      check("restart_irq_cycle", 32'(irq_cyc), 61);
      check("restart_irq_count", 32'(irq_cnt), 1);
      check("restart_sdo_bits",  32'(bits),    'h80);
      @(negedge clk);
      check("restart_sb", 32'(bus.sb), 'h00);
      step(1);

      // SB write protection while busy, and SC-over-SB priority.
      sdata_in = 1'b1;
      write_sb(8'h12);
      write_sc(8'h81);
      step(1);
      write_sb(8'h55);
      @(negedge clk);
      check("sb_protect", 32'(bus.sb), 'h12);
      write_sc(8'h01);
      step(1);
      bus.din   = 8'h80;
      bus.wr_sb = 1'b1;
      bus.wr_sc = 1'b1;
      step(1);
      bus.wr_sb = 1'b0;
      bus.wr_sc = 1'b0;
      @(negedge clk);
      check("prio_sb",   32'(bus.sb),   'h12);
      check("prio_busy", 32'(bus.busy), 'h1);
      check("prio_sc",   32'(bus.sc),   'hFE);
      check("prio_sclk", 32'(sclk_out), 'h1);
      write_sc(8'h00);
      step(2);

      // External transfer: cable clocks 8 bits of 8'hC3 in, 8'h3C out.
      write_sb(8'h3C);
      write_sc(8'h80);
      irq0     = irq_total;
      sclk_ok  = 1'b1;
      ext_bits = 8'h00;
      pat      = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         sclk_in  = 1'b0;
         sdata_in = pat[7-i];
         for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (sclk_out !== 1'b1) sclk_ok = 1'b0;
            if (j == 9) ext_bits = {ext_bits[6:0], sdata_out};
            @(posedge clk);
            #1;
         end
         sclk_in = 1'b1;
         for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (sclk_out !== 1'b1) sclk_ok = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      step(5);
      @(negedge clk);
      check("ext_sb",      32'(bus.sb),              'hC3);
      check("ext_sdo",     32'(ext_bits),            'h3C);
      check("ext_irq",     32'(irq_total - irq0),    1);
      check("ext_sclk_hi", 32'(sclk_ok),             1);
      check("ext_busy",    32'(bus.busy),            'h0);
      check("ext_sc",      32'(bus.sc),              'h7E);

      // Cable clock edges while idle must do nothing.
      irq0 = irq_total;
      for (int i = 0; i < 4; i++) begin
         sclk_in = 1'b0;
         step(6);
         sclk_in = 1'b1;
         step(6);
      end
      @(negedge clk);
      check("idle_edges_sb",  32'(bus.sb),           'hC3);
      check("idle_edges_irq", 32'(irq_total - irq0), 0);
      step(1);

      // Reset during bit 5 of an internal transfer.
      sdata_in = 1'b1;
      write_sb(8'hA5);
      write_sc(8'h81);
      step(37);
      irq0 = irq_total;
      rst  = 1'b1;
      step(1);
      rst  = 1'b0;
      @(negedge clk);
      check("rst_mid_sb",   32'(bus.sb),    'h00);
      check("rst_mid_sc",   32'(bus.sc),    'h7E);
      check("rst_mid_sclk", 32'(sclk_out),  'h1);
      check("rst_mid_sdo",  32'(sdata_out), 'h1);
      check("rst_mid_irq",  32'(bus.irq),   'h0);
      step(81);
      check("rst_mid_no_irq", 32'(irq_total - irq0), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
